// File: rtl/mips_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the MIPS HI/LO pair.
// Optional MULDIV_EARLY_OUT_EN: multiply ends once the remaining multiplier bits are zero.
module mips_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        clock_enable,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        mf_req,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic        sign_a;
  logic        sign_b;
  logic        is_div;
  logic        div_zero;

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] mul_acc_nxt;
  logic [31:0] mplier_nxt;
  logic        mul_last;
  logic        early;
  logic [32:0] div_sh;
  logic        div_ok;
  logic [31:0] div_diff;
  logic [63:0] div_acc_nxt;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign ready = (state == IDLE);
  assign busy  = ~ready;
  assign stall = mf_req & busy;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & op_a[31];
  assign b_neg     = is_signed & op_b[31];
  assign a_mag     = a_neg ? (32'd0 - op_a) : op_a;
  assign b_mag     = b_neg ? (32'd0 - op_b) : op_b;

  assign mul_acc_nxt = mplier[0] ? (acc + mcand) : acc;
  assign mplier_nxt  = mplier >> 1;

`ifdef MULDIV_EARLY_OUT_EN
  assign early = (mplier_nxt == '0);
`else
  assign early = 1'b0;
`endif

  assign mul_last = (cnt == 5'd31) | early;

  // Shifted partial remainder can reach 33 bits; the low 32 of the difference are exact when it fits.
  assign div_sh      = acc[63:31];
  assign div_ok      = (div_sh >= {1'b0, mcand[31:0]});
  assign div_diff    = div_sh[31:0] - mcand[31:0];
  assign div_acc_nxt = div_ok ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

  assign prod_fix = (sign_a ^ sign_b) ? (64'd0 - acc) : acc;
  assign quo_fix  = div_zero ? '1 : ((sign_a ^ sign_b) ? (32'd0 - acc[31:0]) : acc[31:0]);
  assign rem_fix  = sign_a ? (32'd0 - acc[63:32]) : acc[63:32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (clock_enable) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001: begin
                state  <= MUL;
                cnt    <= '0;
                acc    <= '0;
                mcand  <= {32'd0, a_mag};
                mplier <= b_mag;
                sign_a <= a_neg;
                sign_b <= b_neg;
                is_div <= 1'b0;
              end
              3'b010, 3'b011: begin
                state    <= DIV;
                cnt      <= '0;
                acc      <= {32'd0, a_mag};
                mcand    <= {32'd0, b_mag};
                sign_a   <= a_neg;
                sign_b   <= b_neg;
                is_div   <= 1'b1;
                div_zero <= (op_b == '0);
              end
              3'b100:  hi <= op_a;
              3'b101:  lo <= op_a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc    <= mul_acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier_nxt;
            cnt    <= cnt + 5'd1;
            if (mul_last) state <= FIX;
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= div_acc_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: arithmetic reference model, randomized ops with enable/stall noise.
`timescale 1ns/1ps
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clock_enable = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        mf_req = 1'b0;
  logic        ready, busy, done, stall;
  logic [31:0] hi, lo;

  mips_muldiv_unit dut (
    .clk(clk), .reset(reset), .clock_enable(clock_enable), .start(start),
    .op(op), .op_a(op_a), .op_b(op_b), .flush(flush), .mf_req(mf_req),
    .ready(ready), .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned xfer;
    int unsigned lat;
    logic [2:0]  op;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned en_cnt = 0;
  int unsigned last_pop = 32'hFFFF_FFFF;
  logic [31:0] arch_hi = '0;
  logic [31:0] arch_lo = '0;
  bit          in_flight = 1'b0;
  bit          ce_rand = 1'b0;
  bit          mf_force = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference: plain 64-bit arithmetic; latency from operand magnitude when early-out is built in.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el,
                                output int unsigned lat);
    longint      sa, sb, r;
    logic [63:0] u;
    logic [31:0] mag;
    int unsigned iters;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 33;
    eh = '0;
    el = '0;
    case (o)
      3'd0: begin r = sa * sb; u = r; eh = u[63:32]; el = u[31:0]; end
      3'd1: begin u = {32'd0, a} * {32'd0, b}; eh = u[63:32]; el = u[31:0]; end
      default: begin
        if (b == 0) begin
          el = 32'hFFFF_FFFF; eh = a;
        end else if (o == 3'd2) begin
          r = sa / sb; u = r; el = u[31:0];
          r = sa % sb; u = r; eh = u[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (o == 3'd0 || o == 3'd1) begin
      mag = (o == 3'd0 && b[31]) ? (32'd0 - b) : b;
      iters = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) iters = i + 1;
      lat = iters + 1;
    end
`else
    mag = '0;
    iters = 0;
`endif
  endfunction

  always @(posedge clk) if (clock_enable && reset) en_cnt <= en_cnt + 1;

  always @(posedge clk) begin
    #2;
    clock_enable = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    mf_req       = ce_rand ? $urandom_range(0, 1) : mf_force;
  end

  // Monitor: pops one entry per fresh done pulse, checks handshake and HI/LO hold every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (done && en_cnt != last_pop) begin
      last_pop = en_cnt;
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("result_hi op%0d", e.op), {32'd0, hi}, {32'd0, e.hi});
        chk($sformatf("result_lo op%0d", e.op), {32'd0, lo}, {32'd0, e.lo});
        chk($sformatf("latency op%0d", e.op), 64'(en_cnt - e.xfer), 64'(e.lat));
        arch_hi = e.hi;
        arch_lo = e.lo;
        in_flight = 1'b0;
      end
    end
    if (reset) begin
      chk("ready", {63'd0, ready}, {63'd0, !in_flight});
      chk("busy", {63'd0, busy}, {63'd0, in_flight});
      chk("stall", {63'd0, stall}, {63'd0, mf_req && in_flight});
      chk("hi_hold", {32'd0, hi}, {32'd0, arch_hi});
      chk("lo_hold", {32'd0, lo}, {32'd0, arch_lo});
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit track);
    int unsigned guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    op = o; op_a = a; op_b = b; start = 1'b1;
    while (!(ready && clock_enable)) begin
      guard++;
      if (guard > 500) begin
        n_cmp++; n_bad++;
        $display("FAIL issue_timeout: got ready=%0b expected ready=1 within 500 cycles", ready);
        start = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (o <= 3'd3) begin
      in_flight = 1'b1;
      if (track) begin
        model(o, a, b, e.hi, e.lo, e.lat);
        e.xfer = en_cnt;
        e.op = o;
        sb_q.push_back(e);
      end
    end else if (o == 3'd4) begin
      arch_hi = a;
    end else if (o == 3'd5) begin
      arch_lo = a;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic drain();
    int unsigned guard;
    guard = 0;
    while ((in_flight || sb_q.size() != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  initial begin
    logic [2:0] ro;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    reset = 1'b1;

    issue(3'd4, 32'h1234_5678, 32'd0, 1'b1);
    @(negedge clk);
    chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
    chk("mthi_done", {63'd0, done}, 64'd0);
    issue(3'd5, 32'hCAFE_F00D, 32'd0, 1'b1);

    // Reset in the middle of a divide clears HI/LO too
    issue(3'd2, 32'h0001_0000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    in_flight = 1'b0;
    arch_hi = '0;
    arch_lo = '0;
    @(negedge clk);
    chk("midrst_ready", {63'd0, ready}, 64'd1);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    reset = 1'b1;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd3, 32'd7, 32'd0, 1'b1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(3'd1, 32'd5, 32'd3, 1'b1);
    issue(3'd2, 32'h8000_0000, 32'd0, 1'b1);
    drain();

    issue(3'd1, 32'hFFFF_1234, 32'h0000_ABCD, 1'b1);
    @(negedge clk);
    mf_force = 1'b1;
    repeat (3) @(negedge clk);
    mf_force = 1'b0;
    op = 3'd4; op_a = 32'hDEAD_BEEF; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    drain();

    // Abort a multiply on its fifth step
    issue(3'd1, 32'h0BAD_F00D, 32'h0123_4567, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_flight = 1'b0;
    @(negedge clk);
    chk("flush_ready", {63'd0, ready}, 64'd1);
    repeat (40) @(negedge clk);

    ce_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      if (ro > 3'd5 && $urandom_range(0, 1) == 0) ro = 3'd2;
      issue(ro, pick(), pick(), 1'b1);
    end
    drain();
    ce_rand = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected finish before 3ms");
    $fatal(1, "watchdog");
  end

endmodule
